// File: rtl/rx_deserializer_pkg.sv
// Shared types and constants for the receive-side CADU deserializer.
package rx_deserializer_pkg;

  localparam int CPB_W = 32;

  typedef enum logic {IDLE, RECV} rx_state_e;

  // Number of serial bits in one CADU of the given byte length.
  function automatic int frame_bits(input int cadu_width);
    return cadu_width * 8;
  endfunction

endpackage

// File: rtl/rx_deserializer_if.sv
// Serial-in / parallel-out bus of the CADU deserializer.
// master: line side driving the serial stream and observing the CADU.
// slave : the deserializer itself.
interface rx_deserializer_if
  import rx_deserializer_pkg::*;
#(
  parameter int CADU_WIDTH = 5
);

  logic                      data_i;
  logic                      valid_i;
  logic [CPB_W-1:0]          cycles_per_bit;
  logic [CADU_WIDTH*8-1:0]   data_o;
  logic                      valid_o;
  logic                      frame_err_o;

  modport master (
    output data_i, valid_i, cycles_per_bit,
    input  data_o, valid_o, frame_err_o
  );

  modport slave (
    input  data_i, valid_i, cycles_per_bit,
    output data_o, valid_o, frame_err_o
  );

endinterface

// File: rtl/rx_deserializer_sampler.sv
// Per-bit timing for the deserializer: cycle counter inside a bit, the
// sample/push strobe and the end-of-bit flag. Optional RX_DESER_MAJORITY_EN
// replaces the single centre sample by a 2-of-3 vote around the centre.
module rx_deserializer_sampler
  import rx_deserializer_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,     // cycle 0 of bit 0 (FSM leaving IDLE)
  input  logic             active,    // RECV cycle with the serial input valid
  input  logic [CPB_W-1:0] cpb_in,
  input  logic             ser_bit,
  output logic             push,      // push_bit is to be shifted in this cycle
  output logic             push_bit,
  output logic             bit_last   // this is the last cycle of the current bit
);

  logic [CPB_W-1:0] cpb_q;
  logic [CPB_W-1:0] cyc_cnt;
  logic [CPB_W-1:0] cpb_eff;
  logic [CPB_W-1:0] cyc_eff;
  logic [CPB_W-1:0] centre;
  logic             en;

  // A bit period of zero clocks is meaningless; treat it as one.
  function automatic logic [CPB_W-1:0] cpb_clamp(input logic [CPB_W-1:0] c);
    return (c == '0) ? CPB_W'(1) : c;
  endfunction

  // On the start cycle the bit period comes straight from the input and the
  // counter is implicitly zero, so that cycle already belongs to bit 0.
  assign en       = start | active;
  assign cpb_eff  = start ? cpb_clamp(cpb_in) : cpb_q;
  assign cyc_eff  = start ? '0 : cyc_cnt;
  assign centre   = cpb_eff >> 1;
  assign bit_last = (cyc_eff == cpb_eff - CPB_W'(1));

`ifdef RX_DESER_MAJORITY_EN
  logic early_q;
  logic mid_q;
  logic maj_mode;

  // Two-of-three vote; the third sample is the live input.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign maj_mode = (cpb_eff >= CPB_W'(3));
  assign push     = maj_mode ? (cyc_eff == centre + CPB_W'(1)) : (cyc_eff == centre);
  assign push_bit = maj_mode ? majority3(early_q, mid_q, ser_bit) : ser_bit;

  // Capture the samples at centre-1 and centre for the vote.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      early_q <= 1'b0;
      mid_q   <= 1'b0;
    end else if (en) begin
      if (cyc_eff == centre - CPB_W'(1)) early_q <= ser_bit;
      if (cyc_eff == centre)             mid_q   <= ser_bit;
    end
  end
`else
  assign push     = (cyc_eff == centre);
  assign push_bit = ser_bit;
`endif

  // Bit-period counter; the period is frozen for the whole frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cpb_q   <= CPB_W'(1);
      cyc_cnt <= '0;
    end else if (en) begin
      cpb_q   <= cpb_eff;
      cyc_cnt <= bit_last ? '0 : cyc_eff + CPB_W'(1);
    end else begin
      cyc_cnt <= '0;
    end
  end

endmodule

// File: rtl/rx_deserializer.sv
// CADU deserializer: rebuilds CADU_WIDTH bytes, MSB first, from a serial
// stream held for cycles_per_bit clocks per bit, and strobes the result.
// Build option: RX_DESER_MAJORITY_EN enables 2-of-3 majority bit sampling.
module rx_deserializer
  import rx_deserializer_pkg::*;
#(
  parameter int CADU_WIDTH = 5
)(
  input  logic               clk_i,
  input  logic               rst_i,
  rx_deserializer_if.slave   bus
);

  localparam int N     = frame_bits(CADU_WIDTH);
  localparam int BIT_W = $clog2(N + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N - 1);

  rx_state_e        state_q, state_d;
  logic             start, active, complete, abort;
  logic             push, push_bit, bit_last;
  logic [BIT_W-1:0] bit_cnt;
  logic [N-1:0]     shift_q, shift_next;
  logic [N-1:0]     data_q;
  logic             valid_q, err_q;

  assign start  = (state_q == IDLE) && bus.valid_i;
  assign active = (state_q == RECV) && bus.valid_i;

  rx_deserializer_sampler u_sampler (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start    (start),
    .active   (active),
    .cpb_in   (bus.cycles_per_bit),
    .ser_bit  (bus.data_i),
    .push     (push),
    .push_bit (push_bit),
    .bit_last (bit_last)
  );

  // Shift value including a bit pushed this very cycle, so the final bit of
  // the frame lands in data_o even when it is sampled on the last cycle.
  assign shift_next = push ? {shift_q[N-2:0], push_bit} : shift_q;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, frame completion and abort detection.
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: if (bus.valid_i) state_d = RECV;
      RECV: begin
        if (!bus.valid_i) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (bit_last && bit_cnt == LAST_BIT) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register, bit counter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      bit_cnt <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= complete;
      err_q   <= abort;
      if (start) begin
        shift_q <= push ? {{(N-1){1'b0}}, push_bit} : '0;
        bit_cnt <= bit_last ? BIT_W'(1) : '0;
      end else if (active) begin
        shift_q <= shift_next;
        if (complete) begin
          data_q  <= shift_next;
          bit_cnt <= '0;
        end else if (bit_last) begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end else begin
        bit_cnt <= '0;
      end
    end
  end

  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.frame_err_o = err_q;

endmodule
